// File: rtl/fifo_rd_ctrl.sv
// Read-side controller for sync_FIFO: 2-entry skid buffer turning re/empty/dout into valid/ready.
// Optional 16-bit delivered-word counter on rd_cnt when FIFO_RD_CNT_EN is defined.
module fifo_rd_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_dout,
    output logic             fifo_re,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
`ifdef FIFO_RD_CNT_EN
    ,
    output logic [15:0]      rd_cnt
`endif
);

    logic [WIDTH-1:0] mem0_q;
    logic [WIDTH-1:0] mem1_q;
    logic             head_q;
    logic [1:0]       cnt_q;
    logic             inflight_q;

    logic             pop;
    logic [1:0]       occ;
    logic             wr_idx;

    assign pop       = out_valid & out_ready;
    assign occ       = cnt_q + {1'b0, inflight_q};
    assign wr_idx    = head_q ^ cnt_q[0];
    assign out_valid = (cnt_q != 2'd0);
    assign out_data  = head_q ? mem1_q : mem0_q;

    // A pop frees a slot in the same cycle, so a full buffer can still issue a read.
    assign fifo_re = rst_n & ~flush & ~fifo_empty & ((occ < 2'd2) | pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem0_q     <= '0;
            mem1_q     <= '0;
            head_q     <= 1'b0;
            cnt_q      <= 2'd0;
            inflight_q <= 1'b0;
        end else if (flush) begin
            // The word returning this cycle belongs to a discarded read; drop it.
            head_q     <= 1'b0;
            cnt_q      <= 2'd0;
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= fifo_re;
            if (inflight_q) begin
                if (wr_idx) begin
                    mem1_q <= fifo_dout;
                end else begin
                    mem0_q <= fifo_dout;
                end
            end
            case ({inflight_q, pop})
                2'b10: cnt_q <= cnt_q + 2'd1;
                2'b01: begin
                    cnt_q  <= cnt_q - 2'd1;
                    head_q <= ~head_q;
                end
                2'b11: head_q <= ~head_q;
                default: ;
            endcase
        end
    end

`ifdef FIFO_RD_CNT_EN
    logic [15:0] rd_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_cnt_q <= 16'd0;
        end else if (pop) begin
            rd_cnt_q <= rd_cnt_q + 16'd1;
        end
    end

    assign rd_cnt = rd_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Self-checking bench for fifo_rd_ctrl: behavioural FIFO, queue scoreboard, directed + random phases.
// Checks rd_cnt as well when FIFO_RD_CNT_EN is defined.
module tb_fifo_rd_ctrl;

    logic       clk;
    logic       rst_n = 1'b1;
    logic       flush = 1'b0;
    logic       fifo_empty = 1'b1;
    logic [7:0] fifo_dout = 8'd0;
    logic       fifo_re;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
`ifdef FIFO_RD_CNT_EN
    logic [15:0] rd_cnt;
`endif

    logic       we = 1'b0;
    logic [7:0] wdata = 8'd0;

    int checks = 0;
    int errors = 0;
    int rd_err_cnt = 0;
    int cyc = 0;
    int v_first, v_last, v_cnt, re_cnt;
    int pops_total = 0;

    logic [7:0] fifo_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];

    fifo_rd_ctrl #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .fifo_re    (fifo_re),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data)
`ifdef FIFO_RD_CNT_EN
        ,
        .rd_cnt     (rd_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural sync_FIFO: one-cycle read latency, empty updated at the committing edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_q.delete();
            fifo_dout  <= 8'd0;
            fifo_empty <= 1'b1;
        end else begin
            if (fifo_re) begin
                if (fifo_q.size() == 0) rd_err_cnt <= rd_err_cnt + 1;
                else fifo_dout <= fifo_q.pop_front();
            end
            if (we) fifo_q.push_back(wdata);
            fifo_empty <= (fifo_q.size() == 0);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_phase();
        v_cnt  = 0;
        re_cnt = 0;
        got_q.delete();
    endtask

    // One clock cycle: drive at negedge, sample 1ns later, score any handshake.
    task automatic cycle(input logic w, input logic [7:0] d, input logic rdy, input logic fl);
        @(negedge clk);
        we = w; wdata = d; out_ready = rdy; flush = fl;
        #1;
        cyc++;
`ifdef FIFO_RD_CNT_EN
        chk("rd_cnt", {16'd0, rd_cnt}, pops_total & 32'hFFFF);
`endif
        if (out_valid) begin
            if (v_cnt == 0) v_first = cyc;
            v_last = cyc;
            v_cnt++;
        end
        if (fifo_re) re_cnt++;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pop", {24'd0, out_data}, 32'hFFFF_FFFF);
            end else begin
                chk("out_data_order", {24'd0, out_data}, {24'd0, exp_q.pop_front()});
            end
            got_q.push_back(out_data);
            pops_total++;
        end
        // Everything already pulled out of the FIFO is lost on flush.
        if (fl) exp_q = fifo_q;
        if (w) exp_q.push_back(d);
    endtask

    task automatic preload(input logic [7:0] base, input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, base + 8'(i), 1'b0, 1'b1);
    endtask

    initial begin
        logic [31:0] saved_cnt;
        int nwr;
        int guard;

        // Reset state
        #1 rst_n = 1'b0;
        #2;
        chk("rst_fifo_re", {31'd0, fifo_re}, 0);
        chk("rst_out_valid", {31'd0, out_valid}, 0);
        chk("rst_out_data", {24'd0, out_data}, 0);
`ifdef FIFO_RD_CNT_EN
        chk("rst_rd_cnt", {16'd0, rd_cnt}, 0);
`endif
        @(posedge clk); #2 rst_n = 1'b1;

        // Single word latency
        clear_phase();
        cycle(1'b1, 8'hA5, 1'b1, 1'b0);
        chk("single_re_before", {31'd0, fifo_re}, 0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        chk("single_re_N", {31'd0, fifo_re}, 1);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        chk("single_valid_N1", {31'd0, out_valid}, 0);
        chk("single_re_N1", {31'd0, fifo_re}, 0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        chk("single_valid_N2", {31'd0, out_valid}, 1);
        chk("single_data_N2", {24'd0, out_data}, 32'hA5);
        for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
        chk("single_valid_cycles", v_cnt, 1);
        chk("single_re_count", re_cnt, 1);

        // Burst of 16 with ready high
        preload(8'h00, 16);
        clear_phase();
        for (int i = 0; i < 20; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
        chk("burst_valid_cycles", v_cnt, 16);
        chk("burst_consecutive", v_last - v_first + 1, 16);
        chk("burst_re_count", re_cnt, 16);
        chk("burst_got_count", got_q.size(), 16);
        chk("burst_empty_after", {31'd0, fifo_empty}, 1);

        // Backpressure
        preload(8'h10, 8);
        clear_phase();
        for (int i = 0; i < 10; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0);
        chk("stall_re_count", re_cnt, 2);
        chk("stall_valid", {31'd0, out_valid}, 1);
        chk("stall_data_held", {24'd0, out_data}, 32'h10);
        clear_phase();
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        chk("resume_re_same_cycle", {31'd0, fifo_re}, 1);
        for (int i = 0; i < 12; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
        chk("resume_valid_cycles", v_cnt, 8);
        chk("resume_consecutive", v_last - v_first + 1, 8);
        chk("resume_got_count", got_q.size(), 8);

        // Flush after two reads
        preload(8'h20, 4);
        clear_phase();
        for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0);
        chk("flush_pre_reads", re_cnt, 2);
        saved_cnt = pops_total;
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        chk("flush_re_low", {31'd0, fifo_re}, 0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        chk("flush_valid_drop", {31'd0, out_valid}, 0);
`ifdef FIFO_RD_CNT_EN
        chk("flush_rd_cnt_kept", {16'd0, rd_cnt}, saved_cnt & 32'hFFFF);
`endif
        clear_phase();
        for (int i = 0; i < 8; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
        chk("flush_got_count", got_q.size(), 2);
        if (got_q.size() == 2) begin
            chk("flush_word0", {24'd0, got_q[0]}, 32'h22);
            chk("flush_word1", {24'd0, got_q[1]}, 32'h23);
        end

        // Random writes and random ready
        clear_phase();
        nwr = 0;
        guard = 0;
        while ((nwr < 100 || exp_q.size() != 0) && guard < 2000) begin
            if (nwr < 100 && fifo_q.size() < 16 && $urandom_range(1, 0) == 1) begin
                cycle(1'b1, 8'($urandom), 1'($urandom), 1'b0);
                nwr++;
            end else begin
                cycle(1'b0, 8'h00, 1'($urandom), 1'b0);
            end
            guard++;
        end
        chk("random_drained", exp_q.size(), 0);
        chk("random_got_count", got_q.size(), 100);
        chk("rd_err_never", rd_err_cnt, 0);

        // Asynchronous reset in the middle of a burst
        preload(8'h30, 8);
        clear_phase();
        for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
        chk("pre_reset_valid", {31'd0, out_valid}, 1);
        #3 rst_n = 1'b0;
        exp_q.delete();
        pops_total = 0;
        #1;
        chk("async_rst_valid", {31'd0, out_valid}, 0);
        chk("async_rst_re", {31'd0, fifo_re}, 0);
        chk("async_rst_data", {24'd0, out_data}, 0);
`ifdef FIFO_RD_CNT_EN
        chk("async_rst_rd_cnt", {16'd0, rd_cnt}, 0);
`endif
        @(posedge clk); #2 rst_n = 1'b1;
        clear_phase();
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        chk("post_rst_idle", {31'd0, out_valid}, 0);
        cycle(1'b1, 8'h5A, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
        chk("post_rst_got_count", got_q.size(), 1);
        if (got_q.size() == 1) chk("post_rst_word", {24'd0, got_q[0]}, 32'h5A);
`ifdef FIFO_RD_CNT_EN
        chk("post_rst_rd_cnt", {16'd0, rd_cnt}, 1);
`endif
        chk("rd_err_final", rd_err_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
